// File: rtl/spike_event_logger.sv
// Spike event logger: timestamps rising edges on two neuron spike lines,
// queues them in a 4-deep FIFO and serializes each 16-bit event as two bytes.
module spike_event_logger (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [1:0] spike_in,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow,
  output logic [2:0] fifo_count
);

  // state   | meaning
  // IDLE    | nothing queued, out_valid low
  // SEND_HI | presenting {mask, ts[13:8]} of head entry (loaded once on entry)
  // SEND_LO | presenting ts[7:0] of head entry; handshake pops it
  typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} state_t;

  state_t      state, state_d;
  logic [13:0] ts;
  logic [1:0]  prev, rise;
  logic        evt, push, pop;
  logic [15:0] evt_word, head;
  logic [7:0]  next_hi;
  logic [15:0] mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic        valid_d;
  logic [7:0]  data_d;

  assign rise     = spike_in & ~prev;
  assign evt      = ena && (rise != 2'b00);
  assign evt_word = {rise, ts};
  assign pop      = (state == SEND_LO) && out_valid && out_ready;
  assign push     = evt && ((fifo_count != 3'd4) || pop);
  assign head     = mem[rd_ptr];
  // With a single entry left, the entry following the pop is the one being pushed now.
  assign next_hi  = (fifo_count == 3'd1) ? evt_word[15:8] : mem[rd_ptr + 2'd1][15:8];

  always_ff @(posedge clk) begin
    if (rst) begin
      ts         <= '0;
      prev       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      prev <= spike_in;
      if (ena) ts <= ts + 14'd1;
      if (push) begin
        mem[wr_ptr] <= evt_word;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      if (evt && !push) overflow <= 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
    end else begin
      state     <= state_d;
      out_valid <= valid_d;
      out_data  <= data_d;
    end
  end

  always_comb begin
    state_d = state;
    valid_d = out_valid;
    data_d  = out_data;
    case (state)
      IDLE: begin
        valid_d = 1'b0;
        if (fifo_count != 3'd0) state_d = SEND_HI;
      end
      SEND_HI: begin
        if (!out_valid) begin
          valid_d = 1'b1;
          data_d  = head[15:8];
        end else if (out_ready) begin
          state_d = SEND_LO;
          data_d  = head[7:0];
        end
      end
      SEND_LO: begin
        if (out_ready) begin
          if ((fifo_count != 3'd1) || push) begin
            state_d = SEND_HI;
            data_d  = next_hi;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_spike_event_logger.sv
// Directed self-checking bench for spike_event_logger; collects accepted bytes
// and compares them against hand-computed event encodings.
module tb_spike_event_logger;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [1:0] spike_in;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       overflow;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] rx[$];

  spike_event_logger dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .spike_in   (spike_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && out_valid && out_ready) rx.push_back(out_data);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; ena = 1'b0; spike_in = 2'b00; out_ready = 1'b0;
    step(2);
    rst = 1'b0;
    rx.delete();
  endtask

  task automatic drain(input string tag, input int budget);
    int i = 0;
    while ((fifo_count != 3'd0 || out_valid) && i < budget) begin
      step();
      i++;
    end
    check({tag, "_drained"}, {31'd0, (fifo_count == 3'd0 && !out_valid)}, 32'd1);
  endtask

  task automatic check_bytes(input string tag, input int n, input logic [63:0] exp);
    check({tag, "_len"}, rx.size(), n);
    for (int i = 0; i < n; i++)
      if (i < rx.size()) check($sformatf("%s_b%0d", tag, i), {24'd0, rx[i]}, {24'd0, exp[8*(n-1-i) +: 8]});
  endtask

  initial begin
    logic       pv, pr;
    logic [7:0] pd;

    // reset state and basic latency, event at ts=5
    rst = 1'b1; ena = 1'b0; spike_in = 2'b00; out_ready = 1'b0;
    step(2);
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_data", {24'd0, out_data}, 0);
    check("rst_count", {29'd0, fifo_count}, 0);
    check("rst_ovf", {31'd0, overflow}, 0);
    rst = 1'b0; ena = 1'b1; out_ready = 1'b1;
    step(5);
    spike_in = 2'b01;
    step();
    check("t28_count_n", {29'd0, fifo_count}, 1);
    check("t28_valid_n", {31'd0, out_valid}, 0);
    step();
    check("t28_valid_n1", {31'd0, out_valid}, 0);
    step();
    check("t28_valid_n2", {31'd0, out_valid}, 1);
    check("t28_hi", {24'd0, out_data}, 32'h40);
    step();
    check("t28_valid_n3", {31'd0, out_valid}, 1);
    check("t28_lo", {24'd0, out_data}, 32'h05);
    step();
    check("t28_valid_n4", {31'd0, out_valid}, 0);
    check("t28_count_n4", {29'd0, fifo_count}, 0);

    // simultaneous rise at ts=0x1234
    do_reset();
    ena = 1'b1; out_ready = 1'b1;
    step(4660);
    spike_in = 2'b11;
    step();
    drain("t29", 20);
    check_bytes("t29", 2, 64'hD234);

    // overflow with consumer stalled
    do_reset();
    ena = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      spike_in = (k % 2 == 1) ? 2'b10 : 2'b01;
      step();
      spike_in = 2'b00;
      step();
    end
    check("t30_count", {29'd0, fifo_count}, 4);
    check("t30_ovf", {31'd0, overflow}, 1);
    check("t30_hold_hi", {24'd0, out_data}, 32'h40);
    out_ready = 1'b1;
    drain("t30", 40);
    check_bytes("t30", 8, 64'h40_01_80_03_40_05_80_07);
    check("t30_ovf_sticky", {31'd0, overflow}, 1);

    // toggling ready: data stable while stalled
    do_reset();
    ena = 1'b1;
    step();
    spike_in = 2'b01;
    step();
    spike_in = 2'b11;
    step();
    spike_in = 2'b00;
    for (int i = 0; i < 24; i++) begin
      out_ready = (i % 2 == 0);
      pv = out_valid; pr = out_ready; pd = out_data;
      step();
      if (pv && !pr) begin
        check("t31_hold_data", {24'd0, out_data}, {24'd0, pd});
        check("t31_hold_valid", {31'd0, out_valid}, 1);
      end
    end
    out_ready = 1'b1;
    drain("t31", 20);
    check_bytes("t31", 4, 64'h40_01_80_02);

    // timestamp wrap, then ena=0 freezes ts and blocks events
    do_reset();
    ena = 1'b1; out_ready = 1'b1;
    step(16386);
    spike_in = 2'b01;
    step();
    ena = 1'b0;
    spike_in = 2'b00;
    step();
    spike_in = 2'b10;
    step();
    drain("t32a", 20);
    check_bytes("t32a", 2, 64'h4002);
    rx.delete();
    ena = 1'b1;
    step();
    check("t32_no_evt_held", {29'd0, fifo_count}, 0);
    spike_in = 2'b01;
    step();
    drain("t32b", 20);
    check_bytes("t32b", 2, 64'h4004);

    // reset while in SEND_LO with two entries queued
    do_reset();
    ena = 1'b1;
    step();
    spike_in = 2'b01; step();
    spike_in = 2'b00; step();
    spike_in = 2'b01; step();
    spike_in = 2'b00;
    check("t33_count", {29'd0, fifo_count}, 2);
    out_ready = 1'b1;
    step();
    check("t33_lo", {24'd0, out_data}, 32'h01);
    rst = 1'b1;
    step();
    check("t33_valid", {31'd0, out_valid}, 0);
    check("t33_count_rst", {29'd0, fifo_count}, 0);
    check("t33_ovf", {31'd0, overflow}, 0);
    rst = 1'b0;
    rx.delete();
    step(10);
    check("t33_no_bytes", rx.size(), 0);
    check("t33_idle", {31'd0, out_valid}, 0);

    // level already high at first enabled cycle after reset
    rst = 1'b1; ena = 1'b1; spike_in = 2'b01; out_ready = 1'b1;
    step(2);
    rst = 1'b0;
    rx.delete();
    step();
    drain("t27", 20);
    check_bytes("t27", 2, 64'h4000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_event_logger.md
SPIKE_EVENT_LOGGER -- requirements
Module: spike_event_logger

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port ena, input, 1 bit: event capture enable.
REQ-004 SHALL have port spike_in, input, 2 bits: bit0 is the neuron 1 spike level, bit1 is the neuron 2 spike level.
REQ-005 SHALL have port out_data, output, 8 bits: serialized event byte.
REQ-006 SHALL have port out_valid, output, 1 bit: out_data holds a valid byte.
REQ-007 SHALL have port out_ready, input, 1 bit: the consumer accepts the byte.
REQ-008 SHALL have port overflow, output, 1 bit: sticky flag, set when an event is dropped.
REQ-009 SHALL have port fifo_count, output, 3 bits: number of queued events, 0 to 4.

Function
REQ-010 SHALL keep a 14-bit timestamp counter ts that increments by 1 on each cycle where ena=1, wraps 16383->0, and holds when ena=0.
REQ-011 SHALL register spike_in into prev each cycle; rise[i] = spike_in[i] & ~prev[i].
REQ-012 SHALL create an event on a cycle where ena=1 and rise!=0.
- Event word = {rise[1:0], ts[13:0]}.
- ts is the pre-increment value for that cycle.
- Simultaneous rises on both neurons give one event with mask 2'b11.
REQ-013 SHALL ignore spike_in for event creation when ena=0; prev still updates, so no event is created for a level already high when ena rises.
REQ-014 SHALL queue events in a 4-entry FIFO of 16-bit words, written in order.
REQ-015 SHALL accept a push when fifo_count<4, or when fifo_count=4 and a pop happens in the same cycle.
REQ-016 SHALL drop the event and set overflow=1 otherwise; overflow is cleared only by rst.
REQ-017 SHALL update fifo_count in the cycle of push/pop; a simultaneous push and pop leaves it unchanged.
REQ-018 SHALL serialize through an FSM with states IDLE, SEND_HI, SEND_LO.
- IDLE: if fifo_count>0, go to SEND_HI; out_valid=0.
- SEND_HI: out_valid=1, out_data={mask[1:0], ts[13:8]} of the head entry; on out_valid&out_ready go to SEND_LO.
- SEND_LO: out_valid=1, out_data=ts[7:0]; on out_valid&out_ready pop the head, then go to SEND_HI if entries remain after the pop, else IDLE.
REQ-019 SHALL register out_data and out_valid, and hold out_data stable while out_valid=1 and out_ready=0.
REQ-020 SHALL give a latency of 2 cycles: an event written at edge N shows out_valid=1 after edge N+2 when the FIFO was empty and the FSM was in IDLE.
REQ-021 SHALL keep draining the FIFO regardless of ena.
REQ-022 SHALL ignore out_ready while out_valid=0.
REQ-023 SHALL give back-to-back events at full throughput of 1 byte/cycle when out_ready is held at 1; there are no idle cycles between events.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, set ts=0, prev=2'b00, FIFO empty, fifo_count=0, FSM=IDLE, out_valid=0, out_data=8'h00, overflow=0.
REQ-025 SHALL, on rst asserted mid-transfer, abandon the partial event; after release, out_valid stays 0 until a new event is created.
REQ-026 SHALL treat rst as having priority over all other inputs in the same cycle.
REQ-027 SHALL produce an event at the first enabled cycle after reset if spike_in is high then, because prev resets to 0.

Verification
REQ-028 SHALL be verified by: rst, then ena=1; spike_in=01 rising at ts=5 (cycle 5 after release), out_ready=1 -> bytes 8'h40 then 8'h05, with out_valid high exactly 2 cycles.
REQ-029 SHALL be verified by: spike_in 00->11 at ts=0x1234 -> single event, bytes 8'hD2 then 8'h34.
REQ-030 SHALL be verified by: out_ready=0, 5 distinct rising events -> fifo_count=4, overflow=1; after draining with out_ready=1 -> exactly 8 bytes, for the first 4 events in order.
REQ-031 SHALL be verified by: out_ready toggled 1/0 every cycle during a transfer -> out_data constant while stalled, with no byte lost or duplicated.
REQ-032 SHALL be verified by: ena held at 1 for 16384+3 cycles, spike at ts wrap value 2 -> event ts field 14'd2; ena=0 during a spike -> no event and ts frozen.
REQ-033 SHALL be verified by: rst pulsed while in SEND_LO with 2 entries queued -> out_valid=0, fifo_count=0 and overflow=0 on the next cycle, with no bytes emitted afterward without new spikes.
